// File: rtl/sram_arbiter.sv
// Two-master (fetch/load-store) arbiter onto a single SRAM-like slave port.
// One outstanding transaction; data side has priority with bounded starvation of fetch.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state_q, state_d;
  logic          owner_data_q, owner_data_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ready_q;
  logic          m_wr_q, m_wr_d;
  logic [1:0]    m_size_q, m_size_d;
  logic [3:0]    m_wstrb_q, m_wstrb_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic          starved;

  assign starved = inst_req && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    starve_d     = starve_q;
    m_wr_d       = m_wr_q;
    m_size_d     = m_size_q;
    m_wstrb_d    = m_wstrb_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        // ready_q keeps the first cycle out of reset free of grants
        if (resetn && ready_q) begin
          if (inst_req && (!data_req || starved)) begin
            inst_addr_ok = 1'b1;
            owner_data_d = 1'b0;
            starve_d     = '0;
            m_wr_d       = 1'b0;
            m_size_d     = inst_size;
            m_wstrb_d    = '0;
            m_addr_d     = inst_addr;
            m_wdata_d    = '0;
            state_d      = ADDR;
          end else if (data_req) begin
            data_addr_ok = 1'b1;
            owner_data_d = 1'b1;
            if (!inst_req)
              starve_d = '0;
            else if (!starved)
              starve_d = starve_q + SW'(1);
            m_wr_d    = data_wr;
            m_size_d  = data_size;
            m_wstrb_d = data_wstrb;
            m_addr_d  = data_addr;
            m_wdata_d = data_wdata;
            state_d   = ADDR;
          end
        end
      end
      ADDR: begin
        if (m_addr_ok)
          state_d = DATA;
      end
      DATA: begin
        if (m_data_ok) begin
          if (resetn) begin
            inst_data_ok = !owner_data_q;
            data_data_ok = owner_data_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      starve_q     <= '0;
      ready_q      <= 1'b0;
      m_wr_q       <= 1'b0;
      m_size_q     <= '0;
      m_wstrb_q    <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      starve_q     <= starve_d;
      ready_q      <= 1'b1;
      m_wr_q       <= m_wr_d;
      m_size_q     <= m_size_d;
      m_wstrb_q    <= m_wstrb_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  assign m_req   = (state_q == ADDR);
  assign m_wr    = m_wr_q;
  assign m_size  = m_size_q;
  assign m_wstrb = m_wstrb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign rdata   = m_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_sram_arbiter;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr, m_addr_ok, m_data_ok;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, rdata;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  sram_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .rdata(rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one transaction in flight.
  bit          busy = 0, accepted = 0, own_data = 0, ready = 0;
  int          starve = 0;
  logic        md_wr = 0;
  logic [1:0]  md_size = '0;
  logic [3:0]  md_wstrb = '0;
  logic [31:0] md_addr = '0, md_wdata = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit g_i, g_d, e_ido, e_ddo;
      g_i = 0; g_d = 0; e_ido = 0; e_ddo = 0;
      if (resetn && !busy && ready && (inst_req || data_req)) begin
        if (data_req && !(inst_req && starve == SM)) g_d = 1;
        else g_i = 1;
      end
      if (resetn && busy && accepted && m_data_ok) begin
        e_ido = !own_data;
        e_ddo = own_data;
      end
      chk("inst_addr_ok", inst_addr_ok, g_i);
      chk("data_addr_ok", data_addr_ok, g_d);
      chk("inst_data_ok", inst_data_ok, e_ido);
      chk("data_data_ok", data_data_ok, e_ddo);
      chk("m_req", m_req, busy && !accepted);
      chk("m_wr", m_wr, md_wr);
      chk("m_size", m_size, md_size);
      chk("m_wstrb", m_wstrb, md_wstrb);
      chk("m_addr", m_addr, md_addr);
      chk("m_wdata", m_wdata, md_wdata);
      chk("rdata", rdata, m_rdata);
      if (!resetn) begin
        busy = 0; accepted = 0; own_data = 0; ready = 0; starve = 0;
        md_wr = 0; md_size = '0; md_wstrb = '0; md_addr = '0; md_wdata = '0;
      end else begin
        if (g_i) begin
          busy = 1; accepted = 0; own_data = 0; starve = 0;
          md_wr = 0; md_size = inst_size; md_wstrb = '0; md_addr = inst_addr; md_wdata = '0;
        end else if (g_d) begin
          busy = 1; accepted = 0; own_data = 1;
          starve = inst_req ? ((starve < SM) ? starve + 1 : SM) : 0;
          md_wr = data_wr; md_size = data_size; md_wstrb = data_wstrb;
          md_addr = data_addr; md_wdata = data_wdata;
        end else if (busy && !accepted) begin
          if (m_addr_ok) accepted = 1;
        end else if (busy && m_data_ok) begin
          busy = 0; accepted = 0;
        end
        ready = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] order;
    int ng;
    resetn = 0; inst_req = 0; data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 0;
    inst_size = '0; data_size = '0; data_wstrb = '0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; m_rdata = '0;
    cyc();
    chk_en = 1;
    repeat (2) cyc();

    // first cycle out of reset: request and spurious m_data_ok both ignored
    resetn = 1; data_req = 1; data_addr = 32'h1000; data_size = 2'd2; m_data_ok = 1;
    #2 chk("post_rst_addr_ok", data_addr_ok, 0);
    chk("post_rst_data_ok", data_data_ok, 0);
    cyc(); m_data_ok = 0;
    #2 chk("load_addr_ok", data_addr_ok, 1);
    chk("load_inst_addr_ok", inst_addr_ok, 0);
    cyc(); data_req = 0; data_addr = 32'hFFFF; m_addr_ok = 1;
    #2 chk("load_m_req", m_req, 1);
    chk("load_m_addr", m_addr, 32'h1000);
    chk("load_m_size", m_size, 2);
    chk("load_m_wr", m_wr, 0);
    cyc(); m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    #2 chk("load_m_req_drop", m_req, 0);
    chk("load_data_ok", data_data_ok, 1);
    chk("load_rdata", rdata, 32'hDEADBEEF);
    chk("load_inst_data_ok", inst_data_ok, 0);

    // both request: data first, inst waits until data completes
    cyc(); m_data_ok = 0; inst_req = 1; inst_addr = 32'h400; inst_size = 2'd2;
    data_req = 1; data_addr = 32'h2000; data_wdata = 32'hA5A5A5A5; data_wstrb = 4'hF;
    #2 chk("both_data_win", data_addr_ok, 1);
    chk("both_inst_wait", inst_addr_ok, 0);
    cyc(); data_req = 0; m_addr_ok = 1; m_data_ok = 1;
    #2 chk("addr_spurious_dok", data_data_ok, 0);
    chk("inst_wait_addr", inst_addr_ok, 0);
    cyc(); m_addr_ok = 0; m_data_ok = 0;
    #2 chk("inst_wait_data", inst_addr_ok, 0);
    cyc(); m_data_ok = 1; m_rdata = 32'h1;
    #2 chk("both_data_done", data_data_ok, 1);
    chk("inst_wait_done", inst_addr_ok, 0);
    cyc(); m_data_ok = 0;
    #2 chk("inst_grant", inst_addr_ok, 1);
    chk("inst_grant_dao", data_addr_ok, 0);
    cyc(); inst_req = 0; m_addr_ok = 1;
    #2 chk("inst_m_addr", m_addr, 32'h400);
    chk("inst_m_wdata", m_wdata, 0);
    chk("inst_m_wstrb", m_wstrb, 0);
    cyc(); m_addr_ok = 0; m_data_ok = 1;
    #2 chk("inst_data_ok", inst_data_ok, 1);
    chk("inst_ddo_low", data_data_ok, 0);

    // store with slave accept delayed three cycles; requester fields change meanwhile
    cyc(); m_data_ok = 0; data_req = 1; data_wr = 1; data_wstrb = 4'h3;
    data_wdata = 32'h12345678; data_addr = 32'h3000; data_size = 2'd2;
    #2 chk("store_addr_ok", data_addr_ok, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(); data_req = 0; data_wdata = 32'h0BAD; data_addr = '0; data_wstrb = 4'hF;
      data_wr = 0; m_addr_ok = (i == 3);
      #2 chk("store_m_req", m_req, 1);
      chk("store_m_addr", m_addr, 32'h3000);
      chk("store_m_wdata", m_wdata, 32'h12345678);
      chk("store_m_wstrb", m_wstrb, 4'h3);
      chk("store_m_wr", m_wr, 1);
    end
    cyc(); m_addr_ok = 0; m_data_ok = 1;
    #2 chk("store_done", data_data_ok, 1);

    // reset while in DATA abandons the load
    cyc(); m_data_ok = 0; data_req = 1; data_addr = 32'h5000;
    #2 chk("rst_load_addr_ok", data_addr_ok, 1);
    cyc(); data_req = 0; m_addr_ok = 1; m_data_ok = 1;
    #2 chk("rst_addr_dok", data_data_ok, 0);
    cyc(); m_addr_ok = 0; resetn = 0;
    #2 chk("rst_in_data_dok", data_data_ok, 0);
    cyc(); resetn = 1; m_data_ok = 0;
    #2 chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);

    // fairness: both held high, fast slave
    inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
    order = '0; ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      cyc();
      #2;
      if (inst_addr_ok || data_addr_ok) begin
        order[ng] = inst_addr_ok;
        ng++;
      end
    end
    chk("grant_count", 32'(ng), 10);
    chk("grant_order", {22'b0, order}, 32'h210);

    // randomized traffic, occasional reset
    repeat (3000) begin
      cyc();
      resetn = ($urandom_range(0, 299) != 0);
      inst_req = ($urandom_range(0, 2) != 0);
      data_req = 1'($urandom);
      data_wr = 1'($urandom);
      inst_size = 2'($urandom);
      data_size = 2'($urandom);
      data_wstrb = 4'($urandom);
      inst_addr = $urandom;
      data_addr = $urandom;
      data_wdata = $urandom;
      m_addr_ok = ($urandom_range(0, 2) == 0);
      m_data_ok = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
    end
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the number of consecutive data grants allowed while inst_req is pending.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port inst_req  input  1  fetch-side read request.
REQ-005 SHALL have port inst_size  input  2  fetch access size: 0=byte, 1=half, 2=word.
REQ-006 SHALL have port inst_addr  input  32  fetch address.
REQ-007 SHALL have port inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port inst_data_ok  output  1  fetch read data valid this cycle.
REQ-009 SHALL have port data_req  input  1  load/store request from the execute stage.
REQ-010 SHALL have port data_wr  input  1  1=store, 0=load.
REQ-011 SHALL have port data_size  input  2  load/store size, same encoding as inst_size.
REQ-012 SHALL have port data_wstrb  input  4  store byte enables.
REQ-013 SHALL have port data_addr  input  32  load/store address.
REQ-014 SHALL have port data_wdata  input  32  store data.
REQ-015 SHALL have port data_addr_ok  output  1  load/store request accepted this cycle.
REQ-016 SHALL have port data_data_ok  output  1  load data returned or store completed this cycle.
REQ-017 SHALL have port rdata  output  32  read data, equal to m_rdata and qualified by inst_data_ok or data_data_ok.
REQ-018 SHALL have port m_req  output  1  request to the shared SRAM-like slave.
REQ-019 SHALL have port m_wr, m_size, m_wstrb  output  1/2/4  registered copies of the granted request's write flag, size and byte enables.
REQ-020 SHALL have port m_addr, m_wdata  output  32/32  registered copies of the granted request's address and write data.
REQ-021 SHALL have port m_addr_ok  input  1  slave accepted m_req.
REQ-022 SHALL have port m_data_ok  input  1  slave returns read data or write completion.
REQ-023 SHALL have port m_rdata  input  32  slave read data.

Function
REQ-024 SHALL implement an FSM with states IDLE, ADDR and DATA, and SHALL allow exactly one outstanding slave transaction.
REQ-025 In IDLE, when inst_req or data_req is high, SHALL grant one requester, raise its addr_ok combinationally in that cycle, latch its fields into the m_* registers, record the owner and move to ADDR.
REQ-026 On an inst grant, SHALL drive m_wr=0, m_wstrb=0 and m_wdata=0.
REQ-027 Grant rule: data wins, except that inst wins when inst_req=1 and the starvation counter equals STARVE_MAX.
REQ-028 Starvation counter: +1 on a data grant while inst_req=1, saturating at STARVE_MAX; cleared on an inst grant; cleared on a data grant while inst_req=0.
REQ-029 SHALL never assert inst_addr_ok and data_addr_ok in the same cycle, and SHALL keep both low outside IDLE.
REQ-030 In ADDR, SHALL hold m_req=1 with stable m_* fields until m_addr_ok=1, then move to DATA; m_req SHALL be 0 from the next cycle.
REQ-031 In DATA, on m_data_ok=1, SHALL pulse only the owner's *_data_ok in that same cycle and return to IDLE.
REQ-032 SHALL ignore m_data_ok in IDLE and ADDR, including when m_addr_ok and m_data_ok are high together in ADDR.
REQ-033 Latency: accept in cycle N, m_req first high in N+1, owner data_ok in the m_data_ok cycle; the next grant is possible in the cycle after data_ok, so the minimum is 3 cycles per transaction.
REQ-034 SHALL sample requester fields only in the grant cycle; later requester changes SHALL NOT affect m_*.

Reset
REQ-035 With resetn=0 at a clock edge, SHALL enter IDLE, clear the owner and the starvation counter, and drive m_req, m_wr, m_size, m_wstrb, m_addr and m_wdata to 0.
REQ-036 During reset and in the first cycle after it, all addr_ok and data_ok outputs SHALL be 0; a reset in ADDR or DATA abandons the transaction and issues no data_ok.

Verification
REQ-037 Lone load: data_req=1, addr=0x1000, size=2 -> data_addr_ok same cycle; m_req=1, m_addr=0x1000 next cycle; m_data_ok with m_rdata=0xDEADBEEF -> data_data_ok=1, rdata=0xDEADBEEF.
REQ-038 Both requesting from IDLE, counter 0 -> data granted; inst_addr_ok stays 0 until the data transaction's data_ok has completed.
REQ-039 inst_req and data_req held high, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-040 Store: data_wr=1, wstrb=0x3, wdata=0x12345678, m_addr_ok delayed 3 cycles -> m_req and all m_* fields stable for 4 cycles; data_data_ok on m_data_ok.
REQ-041 Spurious m_data_ok in IDLE or ADDR -> no *_data_ok; resetn=0 while in DATA -> IDLE next cycle, m_req=0, no data_ok.
